// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, halt word and fetch-state encoding.
`default_nettype none
package cpu_pkg;
  localparam int INST_W = 16;
  localparam int ADDR_W = 4;
  localparam logic [INST_W-1:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_CAPT   = 3'd2,
    ST_VALID  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALTED = 3'd5
  } fetch_state_t;
endpackage
`default_nettype wire

// File: rtl/inst_mem.sv
// Single-clock instruction memory, synchronous write and 1-cycle synchronous read.
`default_nettype none
module inst_mem #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);
  logic [INST_W-1:0] mem [2**ADDR_W];

  // Read samples the array before this edge's write lands: same-address reads see old data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, program memory and a valid/ack/done handshake to the control unit.
`default_nettype none
module inst_fetch_unit #(
  parameter int                      ADDR_W     = cpu_pkg::ADDR_W,
  parameter int                      INST_W     = cpu_pkg::INST_W,
  parameter logic [ADDR_W-1:0]       START_ADDR = '0,
  parameter logic [INST_W-1:0]       HALT_WORD  = cpu_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [INST_W-1:0] load_data,
  input  logic              inst_ack,
  input  logic              inst_done,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);
  import cpu_pkg::*;

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [INST_W-1:0] inst_next;
  logic              valid_next;
  logic              mem_we;
  logic [INST_W-1:0] rd_data;

  inst_mem #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= START_ADDR;
      inst_out   <= '0;
      inst_valid <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      inst_out   <= inst_next;
      inst_valid <= valid_next;
      busy       <= (state_next != ST_IDLE) && (state_next != ST_HALTED);
      halted     <= (state_next == ST_HALTED);
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    inst_next  = inst_out;
    valid_next = inst_valid;
    mem_we     = 1'b0;
    case (state)
      ST_IDLE, ST_HALTED: begin
        // Program writes are only honoured while nothing is being fetched.
        mem_we = load_we;
        if (run) begin
          state_next = ST_FETCH;
          pc_next    = START_ADDR;
        end
      end
      ST_FETCH: state_next = ST_CAPT;
      ST_CAPT: begin
        if (rd_data == HALT_WORD) begin
          state_next = ST_HALTED;
        end else begin
          state_next = ST_VALID;
          inst_next  = rd_data;
          valid_next = 1'b1;
        end
      end
      ST_VALID: begin
        if (inst_ack) begin
          state_next = ST_EXEC;
          valid_next = 1'b0;
          pc_next    = pc + 1'b1;
        end
      end
      ST_EXEC: if (inst_done) state_next = ST_FETCH;
      default: state_next = ST_IDLE;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit built with a 4-word memory so PC wrap is reachable.
`default_nettype none
module tb_inst_fetch_unit;
  localparam int AW = 2;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic          inst_ack = 1'b0;
  logic          inst_done = 1'b0;
  logic [IW-1:0] inst_out;
  logic          inst_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AW-1:0] pc;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .run(run), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .inst_ack(inst_ack), .inst_done(inst_done),
    .inst_out(inst_out), .inst_valid(inst_valid), .pc(pc), .busy(busy), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick();
    load_we = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic compare_head(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_inst"}, inst_out, e.inst);
      check({tag, "_pc"}, pc, e.pc);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!inst_valid && n < 12) begin
      tick();
      n++;
    end
    if (!inst_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
    else compare_head(tag);
  endtask

  task automatic do_ack();
    inst_ack = 1'b1; tick(); inst_ack = 1'b0;
  endtask

  task automatic do_done();
    inst_done = 1'b1; tick(); inst_done = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    logic saw_valid = 1'b0;
    while (!halted && n < 8) begin
      tick();
      n++;
      if (inst_valid) saw_valid = 1'b1;
    end
    check({tag, "_halted"}, halted, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_no_valid"}, saw_valid, 1'b0);
  endtask

  initial begin
    logic [IW-1:0] held_inst;

    // Reset with run asserted must still land in IDLE.
    rst = 1'b1; run = 1'b1;
    tick(); tick();
    rst = 1'b0; run = 1'b0;
    check("rst_pc", pc, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);

    // Basic fetch with exact latency.
    load(2'd0, 16'h2A14);
    load(2'd1, 16'hFFFF);
    exp_q.push_back('{inst: 16'h2A14, pc: 2'd0});
    pulse_run();
    check("lat_e0_valid", inst_valid, 0);
    check("lat_e0_busy", busy, 1);
    tick();
    check("lat_e1_valid", inst_valid, 0);
    tick();
    check("lat_e2_valid", inst_valid, 1);
    compare_head("basic");

    // Hold in VALID without ack; writes are dropped meanwhile.
    held_inst = inst_out;
    load_we = 1'b1; load_addr = 2'd0; load_data = 16'hBEEF;
    for (int i = 0; i < 10; i++) tick();
    load_we = 1'b0;
    check("hold_inst", inst_out, held_inst);
    check("hold_pc", pc, 0);
    check("hold_valid", inst_valid, 1);

    do_ack();
    check("ack_pc", pc, 1);
    check("ack_valid", inst_valid, 0);
    check("ack_busy", busy, 1);
    do_done();
    wait_halt("halt1");

    // Rerun from HALTED: mem[0] must still be the original word.
    exp_q.push_back('{inst: 16'h2A14, pc: 2'd0});
    pulse_run();
    check("restart_halted", halted, 0);
    wait_valid("readback");
    do_ack(); do_done();
    wait_halt("halt2");

    // Wrap: four non-halt words, five instructions.
    for (int i = 0; i < 4; i++) load(AW'(i), IW'(i + 1));
    for (int i = 0; i < 5; i++) exp_q.push_back('{inst: IW'((i % 4) + 1), pc: AW'(i % 4)});
    pulse_run();
    for (int i = 0; i < 5; i++) begin
      wait_valid($sformatf("wrap%0d", i));
      do_ack();
      if (i < 4) do_done();
    end

    // Reset while in EXEC.
    check("exec_busy", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_pc", pc, 0);
    check("midrst_valid", inst_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_halted", halted, 0);
    exp_q.push_back('{inst: 16'h0001, pc: 2'd0});
    exp_q.push_back('{inst: 16'h0002, pc: 2'd1});
    exp_q.push_back('{inst: 16'h0003, pc: 2'd2});
    pulse_run();
    wait_valid("retained");
    do_ack(); do_done();

    // ack and done together: only the ack counts, EXEC waits for a later done.
    wait_valid("simul");
    inst_ack = 1'b1; inst_done = 1'b1;
    tick();
    inst_ack = 1'b0; inst_done = 1'b0;
    check("simul_pc", pc, 2);
    for (int i = 0; i < 5; i++) tick();
    check("simul_stuck_valid", inst_valid, 0);
    check("simul_stuck_busy", busy, 1);
    check("simul_stuck_pc", pc, 2);
    do_done();
    wait_valid("after_simul");

    // Load and run in the same IDLE cycle: the fresh word is fetched.
    rst = 1'b1; tick(); rst = 1'b0;
    exp_q.push_back('{inst: 16'h1234, pc: 2'd0});
    load_we = 1'b1; load_addr = 2'd0; load_data = 16'h1234; run = 1'b1;
    tick();
    load_we = 1'b0; run = 1'b0;
    wait_valid("load_run");
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
